// File: rtl/ah_mux_pkg.sv
// Shared definitions for the AH one-hot multiplexor family: error counter width
// and the one-hot legality check used by both the scatter and gather sides.
package ah_mux_pkg;

    localparam int AH_ERRCNT_W  = 8;
    localparam int AH_MAX_SEL_W = 64;

    typedef logic [AH_ERRCNT_W-1:0] ah_errcnt_t;

    // Narrower selects are zero-extended by the caller; the padding cannot add set bits.
    function automatic logic ah_is_onehot(input logic [AH_MAX_SEL_W-1:0] vec);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < AH_MAX_SEL_W; i++) begin
            if (vec[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
            end else begin
                multi = multi;
            end
        end
        return seen & ~multi;
    endfunction

endpackage

// File: rtl/ah_demultiplexor_stream_if.sv
// Handshake bundle between a shared producer, the demultiplexor and its per-lane consumers.
interface ah_demultiplexor_stream_if
    import ah_mux_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 8
);
    logic [WIDTH-1:0]         in_data;
    logic [NUM_OUT-1:0]       in_sel;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_OUT*WIDTH-1:0] out_data;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic                     sel_err;
    ah_errcnt_t               err_count;

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, sel_err, err_count
    );

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, sel_err, err_count
    );

endinterface

// File: rtl/ah_demux_slot.sv
// One-entry register slice for a single output channel: load, drain or reload in one cycle.
module ah_demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next slot state; data only moves on load so an empty slot keeps its last word.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (drain) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/ah_demultiplexor_stream.sv
// Routes one valid/ready stream to one of NUM_OUT registered channel slots by one-hot
// select; words with an illegal select are consumed, dropped and counted.
module ah_demultiplexor_stream
    import ah_mux_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ah_demultiplexor_stream_if.slave bus
);

    logic                     sel_legal_s;
    logic                     sel_free_s;
    logic                     in_ready_s;
    logic                     accept_s;
    logic                     drop_s;
    logic [NUM_OUT-1:0]       load_s;
    logic [NUM_OUT-1:0]       out_valid_s;
    logic [NUM_OUT*WIDTH-1:0] out_data_s;
    logic                     slot_valid_s [NUM_OUT];
    logic [WIDTH-1:0]         slot_data_s  [NUM_OUT];
    logic                     sel_err_q;
    logic                     sel_err_d;
    ah_errcnt_t               err_count_q;
    ah_errcnt_t               err_count_d;

    // Select decode and handshake; in_ready deliberately ignores in_valid.
    always_comb begin
        sel_legal_s = ah_is_onehot(AH_MAX_SEL_W'(bus.in_sel));
        sel_free_s  = |(bus.in_sel & (~out_valid_s | bus.out_ready));
        in_ready_s  = ~sel_legal_s | sel_free_s;
        accept_s    = bus.in_valid & in_ready_s;
        drop_s      = accept_s & ~sel_legal_s;
        if (accept_s && sel_legal_s) begin
            load_s = bus.in_sel;
        end else begin
            load_s = {NUM_OUT{1'b0}};
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        ah_demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load_s[k]),
            .drain     (bus.out_ready[k]),
            .load_data (bus.in_data),
            .valid     (slot_valid_s[k]),
            .data      (slot_data_s[k])
        );
    end

    // Flatten per-slot outputs onto the channel buses.
    always_comb begin
        out_valid_s = {NUM_OUT{1'b0}};
        out_data_s  = {(NUM_OUT*WIDTH){1'b0}};
        for (int k = 0; k < NUM_OUT; k++) begin
            out_valid_s[k]                = slot_valid_s[k];
            out_data_s[k*WIDTH +: WIDTH]  = slot_data_s[k];
        end
    end

    // Error pulse follows every dropped word; the counter sticks at all-ones.
    always_comb begin
        sel_err_d   = drop_s;
        err_count_d = err_count_q;
        if (drop_s && (err_count_q != {AH_ERRCNT_W{1'b1}})) begin
            err_count_d = err_count_q + {{(AH_ERRCNT_W-1){1'b0}}, 1'b1};
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Error reporting registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q   <= 1'b0;
            err_count_q <= {AH_ERRCNT_W{1'b0}};
        end else begin
            sel_err_q   <= sel_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = out_data_s;
    assign bus.sel_err   = sel_err_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_ah_demultiplexor_stream.sv
// Scoreboard bench for ah_demultiplexor_stream: directed corner cases plus a random soak.
module tb_ah_demultiplexor_stream;

    localparam int W = 8;
    localparam int N = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ah_demultiplexor_stream_if #(.WIDTH(W), .NUM_OUT(N)) bus ();

    ah_demultiplexor_stream #(.WIDTH(W), .NUM_OUT(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int drops    = 0;

    logic [7:0] q [N][$];
    logic [7:0] last_data [N];
    logic       exp_sel_err;
    logic [7:0] exp_errcnt;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] prev_sel;

    logic       ready_mode;
    logic [7:0] ready_fixed;
    logic [7:0] ready_rand;
    assign bus.out_ready = ready_mode ? ready_rand : ready_fixed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            q[k].delete();
            last_data[k] = 8'h00;
        end
        exp_sel_err = 1'b0;
        exp_errcnt  = 8'h00;
        prev_stall  = 1'b0;
    endtask

    // Present one word and hold it until the DUT takes it; returns stall cycles.
    task automatic send(input logic [7:0] sel, input logic [7:0] d, output int waited);
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = d;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 500) begin
                check("send_timeout", 32'(waited), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Random consumer readiness, biased towards ready.
    initial begin
        logic [31:0] r;
        ready_rand = 8'hFF;
        forever begin
            @(posedge clk);
            #1;
            r = $urandom | $urandom;
            ready_rand = r[7:0];
        end
    end

    // Monitor and reference model: checks outputs, then applies this cycle's transfers.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                logic [7:0] exp_valid;
                logic       legal;
                logic       rdy_exp;
                logic       nxt_err;
                int         idx;
                check("sel_err", 32'(bus.sel_err), 32'(exp_sel_err));
                check("err_count", 32'(bus.err_count), 32'(exp_errcnt));
                exp_valid = 8'h00;
                for (int k = 0; k < N; k++) begin
                    exp_valid[k] = (q[k].size() != 0);
                    check("out_data", 32'(bus.out_data[k*W +: W]),
                          32'((q[k].size() != 0) ? q[k][0] : last_data[k]));
                end
                check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
                if (prev_stall) begin
                    check("upstream_stable", {16'h0, bus.in_data, bus.in_sel}, {16'h0, prev_data, prev_sel});
                end
                legal = ($countones(bus.in_sel) == 1);
                idx   = 0;
                for (int k = 0; k < N; k++) if (bus.in_sel[k]) idx = k;
                rdy_exp = !legal || (q[idx].size() == 0) || bus.out_ready[idx];
                check("in_ready", 32'(bus.in_ready), 32'(rdy_exp));
                for (int k = 0; k < N; k++) begin
                    if (q[k].size() != 0 && bus.out_ready[k]) void'(q[k].pop_front());
                end
                nxt_err = 1'b0;
                if (bus.in_valid && rdy_exp) begin
                    if (legal) begin
                        q[idx].push_back(bus.in_data);
                        last_data[idx] = bus.in_data;
                    end else begin
                        nxt_err = 1'b1;
                        if (exp_errcnt != 8'hFF) exp_errcnt = exp_errcnt + 8'd1;
                    end
                end
                exp_sel_err = nxt_err;
                prev_stall  = bus.in_valid && !rdy_exp;
                prev_data   = bus.in_data;
                prev_sel    = bus.in_sel;
            end
        end
    end

    initial begin
        int w;
        logic [7:0] s;
        bus.in_valid = 1'b0;
        bus.in_sel   = 8'h00;
        bus.in_data  = 8'h00;
        ready_mode   = 1'b0;
        ready_fixed  = 8'hFF;
        model_clear();

        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_err_count", 32'(bus.err_count), 32'h0);
        check("rst_sel_err", 32'(bus.sel_err), 32'h0);
        check("rst_out_data_lo", bus.out_data[31:0], 32'h0);
        check("rst_out_data_hi", bus.out_data[63:32], 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Reset while slots 2 and 5 hold words.
        ready_fixed = 8'hDB;
        send(8'h04, 8'h3C, w);
        send(8'h20, 8'hC3, w);
        check("pre_rst_valid", 32'(bus.out_valid), 32'h24);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'h0);
        check("async_rst_errcnt", 32'(bus.err_count), 32'h0);
        model_clear();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        ready_fixed = 8'hFF;

        // Single route to channel 3.
        send(8'h08, 8'hA5, w);
        check("route_valid", 32'(bus.out_valid), 32'h08);
        check("route_data", 32'(bus.out_data[31:24]), 32'hA5);
        check("route_others_hi", bus.out_data[63:32], 32'h0);
        check("route_others_lo", 32'(bus.out_data[23:0]), 32'h0);

        // Backpressure on channel 3, then reload in the same cycle it drains.
        ready_fixed  = 8'hF7;
        bus.in_valid = 1'b1;
        bus.in_sel   = 8'h08;
        bus.in_data  = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 32'h0);
            check("bp_hold", 32'(bus.out_data[31:24]), 32'hA5);
        end
        @(posedge clk);
        #1;
        ready_fixed = 8'hFF;
        @(negedge clk);
        check("bp_release_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        ready_fixed  = 8'hF7;
        check("reload_valid", 32'(bus.out_valid[3]), 32'h1);
        check("reload_data", 32'(bus.out_data[31:24]), 32'h5A);

        // Channel 3 stalled must not block channels 0 and 7.
        send(8'h01, 8'h11, w);
        check("indep_ch0_wait", 32'(w), 32'h0);
        send(8'h80, 8'h22, w);
        check("indep_ch7_wait", 32'(w), 32'h0);
        check("indep_valid", 32'(bus.out_valid), 32'h88);
        ready_fixed = 8'hFF;
        repeat (2) @(posedge clk);
        #1;

        // Illegal selects are consumed and counted.
        send(8'h00, 8'hE1, w);
        check("ill0_pulse", 32'(bus.sel_err), 32'h1);
        check("ill0_count", 32'(bus.err_count), 32'h1);
        send(8'h03, 8'hE2, w);
        check("ill3_pulse", 32'(bus.sel_err), 32'h1);
        check("ill3_count", 32'(bus.err_count), 32'h2);
        check("ill_valid", 32'(bus.out_valid), 32'h0);
        @(posedge clk);
        #1;
        check("ill_pulse_end", 32'(bus.sel_err), 32'h0);
        for (int i = 0; i < 300; i++) begin
            s = (i % 2 == 0) ? 8'h00 : 8'hC0;
            send(s, 8'(i), w);
        end
        check("errcnt_saturate", 32'(bus.err_count), 32'hFF);

        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Random soak with random consumer readiness.
        ready_mode = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 3) == 0) begin
                do s = 8'($urandom); while ($countones(s) == 1);
                drops++;
            end else begin
                s = 8'(8'b1 << $urandom_range(0, 7));
            end
            send(s, 8'($urandom), w);
        end
        ready_mode  = 1'b0;
        ready_fixed = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) check("soak_drained", 32'(q[k].size()), 32'h0);
        check("soak_errcnt", 32'(bus.err_count), (drops > 255) ? 32'd255 : 32'(drops));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
